// File: rtl/bin2bcd_pkg.sv
// bin2bcd shared types and constants.
// Optional leading-zero blanking is enabled by BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  localparam int DEF_BIN_W  = 20;
  localparam int DEF_DIGITS = 7;

  // decimal digits needed to hold 2^bin_w - 1
  function automatic int min_digits(input int bin_w);
    longint unsigned lim;
    longint unsigned p;
    int d;
    lim = (64'd1 << bin_w) - 64'd1;
    p = 64'd1;
    d = 0;
    while (p <= lim) begin
      p = p * 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_conv_if.sv
// Start/done handshake bundle for bin2bcd_conv.
// blank exists only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_conv_if
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  ready;
  logic                  done_tick;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;
`endif

  modport master (
    output start, bin,
    input  ready, done_tick, bcd
`ifdef BIN2BCD_BLANK_EN
    , input blank
`endif
  );

  modport slave (
    input  start, bin,
    output ready, done_tick, bcd
`ifdef BIN2BCD_BLANK_EN
    , output blank
`endif
  );

endinterface

// File: rtl/bin2bcd_conv_adj.sv
// Single BCD digit correction cell: add 3 when the digit is 5 or more.
// Carry out of the nibble is dropped by construction.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential double-dabble binary to packed BCD converter.
// Define BIN2BCD_BLANK_EN to add the registered leading-zero mask.
module bin2bcd_conv
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_conv_if.slave io
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;

  if (DIGITS < min_digits(BIN_W)) begin : g_chk
    $error("bin2bcd_conv: DIGITS too small for BIN_W");
  end

  state_t          state;
  state_t          nxt;
  logic [BIN_W-1:0] sh;
  logic [BIN_W-1:0] sh_n;
  logic [BW-1:0]   wk;
  logic [BW-1:0]   wk_n;
  logic [BW-1:0]   adj;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcd_q;
  logic            last;
  logic            accept;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (wk[4*d +: 4]),
      .dout (adj[4*d +: 4])
    );
  end

  assign {wk_n, sh_n} = {adj[BW-2:0], sh, 1'b0};
  assign last   = (cnt == CW'(1));
  assign accept = (state == IDLE) && io.start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE:    nxt = io.start ? OP : IDLE;
      OP:      nxt = last ? DONE : OP;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    io.ready     = (state == IDLE);
    io.done_tick = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh    <= '0;
      wk    <= '0;
      cnt   <= '0;
      bcd_q <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          sh  <= io.bin;
          wk  <= '0;
          cnt <= CW'(BIN_W);
        end
        (state == OP): begin
          sh  <= sh_n;
          wk  <= wk_n;
          cnt <= cnt - CW'(1);
          if (last) bcd_q <= wk_n;
        end
        default: ;
      endcase
    end
  end

  assign io.bcd = bcd_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_n;
  logic [DIGITS-1:0] blank_q;
  logic              zs;

  // a digit blanks only if it and all higher digits are zero
  always_comb begin
    blank_n = '0;
    zs      = 1'b1;
    for (int j = DIGITS - 1; j >= 1; j--) begin
      zs         = zs & (wk_n[4*j +: 4] == 4'd0);
      blank_n[j] = zs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_q <= '0;
    end else if ((state == OP) && last) begin
      blank_q <= blank_n;
    end
  end

  assign io.blank = blank_q;
`endif

endmodule

// File: doc/bin2bcd_conv.md
# bin2bcd_conv

Sequential binary-to-BCD converter (shift-add-3 / double dabble) that sits directly downstream of the Fibonacci generator. It takes the generator's 20-bit result and produces packed decimal digits for the display stage. Conversions are one at a time, started by a single-cycle `start` pulse. Completion is signalled with a one-cycle `done_tick`, mirroring the generator's handshake so that the generator's `done_tick` can drive `start` directly.

## Interface
- `BIN_W`, default 20: binary input width.
- `DIGITS`, default 7: number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W − 1 (elaboration-time check).
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst`  input  1: asynchronous, active-low reset (asserted when 0).
- `start`  input  1: conversion request; sampled only while `ready`=1.
- `bin`  input  BIN_W: unsigned value to convert; sampled on the edge that accepts `start`.
- `ready`  output  1: high exactly while in `IDLE`.
- `done_tick`  output  1: one-cycle pulse while in `DONE`.
- `bcd`  output  4*DIGITS: packed digits; digit 0 (units) in bits [3:0]. Registered and held between conversions.
- `blank`  output  DIGITS: leading-zero mask. Present only when `BIN2BCD_BLANK_EN` is defined.

## Operation
- FSM has three states: `IDLE`, `OP`, `DONE`.
  - `IDLE`:
    - `ready`=1.
    - When `start`=1: load the shift register with `bin`, clear the BCD working register, set the bit counter to BIN_W, then go to `OP`.
  - `OP`, once per cycle:
    - Every working digit ≥ 5 gets +3 (4-bit add, no carry out of the digit).
    - Then shift {BCD working, binary} left by 1 and decrement the counter.
    - The cycle that performs the final (BIN_W-th) shift also loads `bcd` and goes to `DONE`.
  - `DONE`: `done_tick`=1 for one cycle, then unconditionally go to `IDLE`.
  - Illegal state encodings recover to `IDLE`.
- `start` outside `IDLE` is ignored: no queueing, and `bin` is not resampled.
- `bcd` changes only on conversion completion. Intermediate working values never appear on `bcd`.
- Arithmetic:
  - The counter is $clog2(BIN_W+1) bits wide.
  - The working register is 4*DIGITS bits. The parameter check guarantees no digit exceeds 9 at the end.
  - Inputs are unsigned; no sign handling.
- Reset, at any time including mid-conversion:
  - Immediately forces `IDLE`, `ready`=1, `done_tick`=0, `bcd`=0, and all working registers, counter and `blank` to 0.
  - Any conversion in progress is discarded.

## Timing
- Output reset values: `ready`=1, `done_tick`=0, `bcd`=0, `blank`=0.
- Latency: with `start` sampled at edge k:
  - `ready` drops after edge k.
  - Shifts occur on edges k+1 … k+BIN_W.
  - `bcd` is valid and `done_tick`=1 after edge k+BIN_W.
  - `ready`=1 again after edge k+BIN_W+1.
- Default throughput is 22 cycles per conversion (start cycle + 20 `OP` cycles + 1 `DONE` cycle).
- `start` asserted in the same cycle `ready` returns high is accepted (back-to-back conversions).
- `ready` and `done_tick` are decoded from the registered state; no combinational path from `start`.

## Configuration
- `BIN2BCD_BLANK_EN` defined:
  - A `blank` register is loaded together with `bcd`.
  - `blank[j]`=1 when digit j and every digit above it are 0, for j ≥ 1.
  - `blank[0]` is always 0, so a value of 0 displays as a single "0".
- `BIN2BCD_BLANK_EN` undefined: the `blank` port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `bin2bcd_pkg` holds:
  - the `state_t` enum (`IDLE`, `OP`, `DONE`);
  - constants `BCD_ADJ_THRESH`=4'd5 and `BCD_ADJ_ADD`=4'd3;
  - default width constants.
- Sub-module `bcd_digit_adj`: combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times by a generate loop.

## Test plan
- Reset mid-conversion: start with `bin`=1048575, drop `rst` at cycle 10 → `bcd`=0, `ready`=1, and no `done_tick` ever appears for that conversion.
- `bin`=0 → after 21 cycles `done_tick` pulses once, `bcd`=28'h0000000, and with the macro `blank`=7'b1111110.
- `bin`=6765 → `bcd`=28'h0006765 and `blank`=7'b1110000. `done_tick` arrives exactly BIN_W cycles after the start edge.
- `bin`=1048575 (max) → `bcd`=28'h1048575 and `blank`=7'b0000000.
- `start` pulsed with `bin`=9 during `OP` of a conversion of 55 → result is 28'h0000055, only one `done_tick`, and `bcd` stays unchanged until completion.
- Back-to-back: `start` held high with `bin`=1 then `bin`=2 → two `done_tick`s 22 cycles apart, `bcd`=1 then 2.
